demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the routed data word.
REQ-002 Parameter CNT_WIDTH, default 8, width of the illegal-address counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  source presents a word.
REQ-006 in_ready  output  1  router accepts the word this cycle.
REQ-007 in_data  input  DATA_WIDTH  word to route.
REQ-008 in_addr  input  3  one-hot destination: 3'b001 port 0, 3'b010 port 1, 3'b100 port 2.
REQ-009 out_valid  output  3  bit k: port k holds a word.
REQ-010 out_ready  input  3  bit k: sink k consumes the word this cycle.
REQ-011 out_data0, out_data1, out_data2  output  DATA_WIDTH each  head word of each port.
REQ-012 err_pulse  output  1  one-cycle flag: illegal address was dropped.
REQ-013 err_count  output  CNT_WIDTH  saturating count of dropped words.

Function
REQ-014 Input transfer occurs when in_valid and in_ready are both 1 at a rising edge; output transfer on port k occurs when out_valid[k] and out_ready[k] are both 1.
REQ-015 Each port has a private 2-entry FIFO with a 2-bit occupancy count (0..2), 1-bit write pointer and 1-bit read pointer, both wrapping 1->0.
REQ-016 Legal in_addr: in_ready = 1 when the addressed FIFO's registered occupancy is below 2. The same-cycle pop on that port does not raise in_ready.
REQ-017 Illegal in_addr (000, 011, 101, 110, 111): in_ready = 1 unconditionally. The word is discarded, err_pulse is 1 in the following cycle, and err_count increments.
REQ-018 err_count saturates at all-ones and does not wrap.
REQ-019 Latency: a word accepted at edge N drives out_valid/out_data of its port from edge N onward (visible cycle N+1) when that FIFO was empty. No combinational path exists from in_* to out_*.
REQ-020 out_valid[k] = (occupancy_k != 0). out_data_k = entry at read pointer. out_data_k holds stable while out_valid[k] = 1 and out_ready[k] = 0.
REQ-021 Per-port ordering is preserved. There are no ordering guarantees across ports.
REQ-022 Simultaneous push and pop on the same port with occupancy 1: occupancy stays 1, both pointers advance, and the new word becomes head.
REQ-023 Pop on an empty port (out_ready = 1, out_valid = 0) has no effect. Ports are independent: back-pressure on one port never blocks a word addressed to another.
REQ-024 in_ready is a function only of in_addr, in_valid-independent, and registered occupancy. It is never combinationally derived from out_ready.

Reset
REQ-025 While reset = 1, regardless of clk, all occupancy counts and pointers clear to 0, and out_valid = 3'b000, err_pulse = 0, err_count = 0.
REQ-026 FIFO storage contents need not be reset. out_data_k is don't-care while out_valid[k] = 0.
REQ-027 Reset asserted mid-operation discards all buffered words immediately. The first legal word after reset deassertion is accepted normally.

Structure
REQ-028 Shared package holds the one-hot port-select constants (PORT0 = 3'b001, PORT1 = 3'b010, PORT2 = 3'b100) and the FIFO depth constant (2).
REQ-029 One sub-module, router_fifo2 (2-entry FIFO with valid/ready on both sides), is instantiated three times. demux_router holds the address decode, error logic and counter.

Verification
REQ-030 Legal routing: after reset, push 0x11 addr 001, 0x22 addr 010, 0x33 addr 100 with all out_ready = 1. Expect each word on its port one cycle after acceptance, and err_count = 0.
REQ-031 Full and back-pressure: out_ready[1] = 0. Push 0xA1, 0xA2, 0xA3 to addr 010. Expect in_ready = 0 on the third word. Then push 0xB0 to addr 001 and expect it accepted. Release out_ready[1] and expect 0xA1, 0xA2, 0xA3 in order.
REQ-032 Illegal address: push 0xDEAD with addr 011, then 000. Expect in_ready = 1, no out_valid change, err_pulse high one cycle after each push, and err_count = 2. Force 300 illegal pushes with CNT_WIDTH = 8 and expect err_count = 255.
REQ-033 Simultaneous push/pop: port 2 holding 0x01 with out_ready[2] = 1, push 0x02 to addr 100 in the same cycle. Expect occupancy 1 and out_data2 = 0x02 next cycle.
REQ-034 Reset mid-operation: fill port 0 with 0x10, 0x20, then pulse reset asynchronously between edges. Expect out_valid = 000 immediately and err_count = 0. After release, push 0x30 to addr 001 and expect it to be the first word out.

Source files
------------

// File: rtl/demux_router_pkg.sv
// Shared constants for the 3-port demux router: one-hot port selects and FIFO depth.
package demux_router_pkg;
  localparam int NUM_PORTS  = 3;
  localparam int FIFO_DEPTH = 2;

  localparam logic [2:0] PORT0 = 3'b001;
  localparam logic [2:0] PORT1 = 3'b010;
  localparam logic [2:0] PORT2 = 3'b100;
endpackage

// File: rtl/router_fifo2.sv
// 2-entry FIFO with valid/ready on both sides; storage is intentionally not reset.
module router_fifo2
  import demux_router_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data
);
  logic [1:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  push, pop;

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign push_ready = (cnt_q < 2'(FIFO_DEPTH));
  assign pop_valid  = (cnt_q != 2'd0);
  assign pop_data   = mem_q[rd_q];
  assign push       = push_valid & push_ready;
  assign pop        = pop_ready & pop_valid;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    if (push) wr_d = ~wr_q;
    if (pop)  rd_d = ~rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/demux_router.sv
// Routes one-hot addressed words into three independent 2-deep port FIFOs;
// illegal addresses are swallowed and counted.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_addr,
  output logic [2:0]            out_valid,
  input  logic [2:0]            out_ready,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_count
);
  logic [NUM_PORTS-1:0]                 port_hit;
  logic [NUM_PORTS-1:0]                 fifo_ready;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] fifo_data;
  logic                                 legal;
  logic                                 err_pulse_q, err_pulse_d;
  logic [CNT_WIDTH-1:0]                 err_count_q, err_count_d;

  assign port_hit = {in_addr == PORT2, in_addr == PORT1, in_addr == PORT0};
  assign legal    = |port_hit;
  // Illegal words are always accepted so a bad address can never stall the source.
  assign in_ready = legal ? |(port_hit & fifo_ready) : 1'b1;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    router_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (in_valid & port_hit[k]),
      .push_ready (fifo_ready[k]),
      .push_data  (in_data),
      .pop_valid  (out_valid[k]),
      .pop_ready  (out_ready[k]),
      .pop_data   (fifo_data[k])
    );
  end

  assign out_data0 = fifo_data[0];
  assign out_data1 = fifo_data[1];
  assign out_data2 = fifo_data[2];

  always_comb begin
    err_pulse_d = in_valid & ~legal;
    err_count_d = err_count_q;
    if (err_pulse_d && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_demux_router.sv
// Directed vector bench for demux_router: routing, back-pressure, illegal
// addresses, push/pop overlap, counter saturation and async reset.
module tb_demux_router;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_addr;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [DW-1:0] out_data0, out_data1, out_data2;
  logic          err_pulse;
  logic [CW-1:0] err_count;

  int checks   = 0;
  int failures = 0;

  demux_router #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [2:0]    addr;
    logic [DW-1:0] data;
    logic [2:0]    ordy;
    logic          exp_rdy;
    logic [2:0]    exp_ov;
    logic [DW-1:0] exp_d0, exp_d1, exp_d2;
    logic          exp_err;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic vld, logic [2:0] addr, logic [DW-1:0] data,
                              logic [2:0] ordy, logic exp_rdy, logic [2:0] exp_ov,
                              logic [DW-1:0] d0, logic [DW-1:0] d1, logic [DW-1:0] d2,
                              logic exp_err, logic [CW-1:0] exp_cnt);
    vec_t v;
    v.vld = vld; v.addr = addr; v.data = data; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
    v.exp_d0 = d0; v.exp_d1 = d1; v.exp_d2 = d2;
    v.exp_err = exp_err; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [2:0] addr, input logic [DW-1:0] data,
                       input logic [2:0] ordy);
    in_valid  = vld;
    in_addr   = addr;
    in_data   = data;
    out_ready = ordy;
  endtask

  initial begin
    // {vld, addr, data, out_ready} -> {in_ready, out_valid, d0, d1, d2, err_pulse, err_count}
    vecs[0]  = mk(1, 3'b001, 32'h11,   3'b111, 1, 3'b001, 32'h11, 0, 0, 0, 0);
    vecs[1]  = mk(1, 3'b010, 32'h22,   3'b111, 1, 3'b010, 0, 32'h22, 0, 0, 0);
    vecs[2]  = mk(1, 3'b100, 32'h33,   3'b111, 1, 3'b100, 0, 0, 32'h33, 0, 0);
    vecs[3]  = mk(0, 3'b001, 32'h0,    3'b111, 1, 3'b000, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 3'b010, 32'hA1,   3'b101, 1, 3'b010, 0, 32'hA1, 0, 0, 0);
    vecs[5]  = mk(1, 3'b010, 32'hA2,   3'b101, 1, 3'b010, 0, 32'hA1, 0, 0, 0);
    vecs[6]  = mk(1, 3'b010, 32'hA3,   3'b101, 0, 3'b010, 0, 32'hA1, 0, 0, 0);
    vecs[7]  = mk(1, 3'b001, 32'hB0,   3'b101, 1, 3'b011, 32'hB0, 32'hA1, 0, 0, 0);
    vecs[8]  = mk(0, 3'b001, 32'h0,    3'b111, 1, 3'b010, 0, 32'hA2, 0, 0, 0);
    vecs[9]  = mk(1, 3'b010, 32'hA3,   3'b111, 1, 3'b010, 0, 32'hA3, 0, 0, 0);
    vecs[10] = mk(0, 3'b001, 32'h0,    3'b111, 1, 3'b000, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 3'b011, 32'hDEAD, 3'b111, 1, 3'b000, 0, 0, 0, 1, 1);
    vecs[12] = mk(1, 3'b000, 32'hDEAD, 3'b111, 1, 3'b000, 0, 0, 0, 1, 2);
    vecs[13] = mk(0, 3'b000, 32'h0,    3'b111, 1, 3'b000, 0, 0, 0, 0, 2);
    vecs[14] = mk(1, 3'b100, 32'h01,   3'b011, 1, 3'b100, 0, 0, 32'h01, 0, 2);
    vecs[15] = mk(1, 3'b100, 32'h02,   3'b111, 1, 3'b100, 0, 0, 32'h02, 0, 2);
    vecs[16] = mk(0, 3'b001, 32'h0,    3'b111, 1, 3'b000, 0, 0, 0, 0, 2);
    vecs[17] = mk(0, 3'b001, 32'h0,    3'b111, 1, 3'b000, 0, 0, 0, 0, 2);

    reset = 1'b1;
    drive(0, 3'b001, '0, 3'b000);
    #2;
    chk("reset out_valid", 32'(out_valid), 32'(3'b000));
    chk("reset err_pulse", 32'(err_pulse), 32'(1'b0));
    chk("reset err_count", 32'(err_count), 32'(8'd0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].addr, vecs[i].data, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov[0]) chk($sformatf("v%0d out_data0", i), out_data0, vecs[i].exp_d0);
      if (vecs[i].exp_ov[1]) chk($sformatf("v%0d out_data1", i), out_data1, vecs[i].exp_d1);
      if (vecs[i].exp_ov[2]) chk($sformatf("v%0d out_data2", i), out_data2, vecs[i].exp_d2);
      chk($sformatf("v%0d err_pulse", i), 32'(err_pulse), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
    end

    // 300 more illegal pushes on top of the 2 already counted: must saturate at 255.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1, 3'b111, 32'(i), 3'b111);
    end
    @(posedge clk);
    #1;
    chk("sat err_count", 32'(err_count), 32'(8'd255));
    chk("sat err_pulse", 32'(err_pulse), 32'(1'b1));
    chk("sat out_valid", 32'(out_valid), 32'(3'b000));
    @(negedge clk);
    drive(0, 3'b001, '0, 3'b111);
    @(posedge clk);
    #1;
    chk("sat hold count", 32'(err_count), 32'(8'd255));
    chk("sat pulse drop", 32'(err_pulse), 32'(1'b0));

    // Fill port 0 while blocked, then pulse reset between edges.
    @(negedge clk);
    drive(1, 3'b001, 32'h10, 3'b000);
    @(negedge clk);
    drive(1, 3'b001, 32'h20, 3'b000);
    @(negedge clk);
    drive(0, 3'b001, '0, 3'b000);
    chk("prerst out_valid", 32'(out_valid), 32'(3'b001));
    chk("prerst out_data0", out_data0, 32'h10);
    chk("prerst full", 32'(in_ready), 32'(1'b0));
    #1;
    reset = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'(3'b000));
    chk("midrst err_count", 32'(err_count), 32'(8'd0));
    #1;
    reset = 1'b0;
    #1;
    chk("postrst in_ready", 32'(in_ready), 32'(1'b1));
    @(negedge clk);
    drive(1, 3'b001, 32'h30, 3'b001);
    @(posedge clk);
    #1;
    chk("postrst out_valid", 32'(out_valid), 32'(3'b001));
    chk("postrst out_data0", out_data0, 32'h30);
    @(negedge clk);
    drive(0, 3'b001, '0, 3'b001);
    @(posedge clk);
    #1;
    chk("postrst drained", 32'(out_valid), 32'(3'b000));
    chk("postrst err_count", 32'(err_count), 32'(8'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
